track_seg_gen: RTL and testbench

Parametrised track/sector generator for the FIR acquisition path. It locks a reference angle from the wafer encoder word when filtering is enabled, then counts forward revolutions ("tracks") relative to that angle. Hysteresis arming rejects encoder jitter near the lock point. It optionally emits power-of-two sector pulses within each track. It sits beside the FIR control logic in the `sys_clk` domain and feeds track/sector markers to the packetiser.

---
 rtl/track_seg_gen.sv | 179 +++++++++++++++++
 tb/tb_track_seg_gen.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/track_seg_gen.sv
// Track/sector generator: locks a reference angle, then counts armed forward revolutions.
// Optional sector pulses are built only when TRACK_SEG_SECTOR_EN is defined.
module track_seg_gen #(
    parameter int DIN_W    = 64,
    parameter int ENC_LSB  = 34,
    parameter int ENC_W    = 18,
    parameter int NUM_W    = 16,
    parameter int SEC_BITS = 3
) (
    input  logic                sys_clk,
    input  logic                sys_rst,
    input  logic                soft_rst,
    input  logic                fir_en,
    input  logic                enc_vld,
    input  logic [DIN_W-1:0]    enc_din,
    input  logic [NUM_W-1:0]    cfg_track_max,
    output logic                lock_vld,
    output logic [ENC_W-1:0]    rel_angle,
    output logic                track_pos,
    output logic [NUM_W-1:0]    track_num,
    output logic                track_done,
    output logic                sector_pos,
    output logic [SEC_BITS-1:0] sector_idx
);

    typedef enum logic [2:0] {IDLE, LOCK, WAIT_ARM, ARMED, DONE} state_t;

    state_t           state_reg, state_next;
    logic [ENC_W-1:0] lock_reg, lock_next;
    logic [ENC_W-1:0] rel_reg, rel_next;
    logic             lock_vld_reg, lock_vld_next;
    logic             track_pos_reg, track_pos_next;
    logic [NUM_W-1:0] track_num_reg, track_num_next;
    logic             track_done_reg, track_done_next;
    logic             sec_load, sec_upd;

    logic [ENC_W-1:0] angle;
    logic [ENC_W-1:0] rel_cur;
    logic [1:0]       quad;
    logic [NUM_W-1:0] num_inc;
    logic             unused_din;

    assign angle      = enc_din[ENC_LSB +: ENC_W];
    assign rel_cur    = angle - lock_reg;
    // Top two bits of rel select the quarter: 00 = [0,Q), 10 = [H,T).
    assign quad       = rel_cur[ENC_W-1 -: 2];
    assign num_inc    = (track_num_reg == '1) ? track_num_reg : track_num_reg + 1'b1;
    assign unused_din = ^enc_din;

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_reg      <= IDLE;
            lock_reg       <= '0;
            rel_reg        <= '0;
            lock_vld_reg   <= 1'b0;
            track_pos_reg  <= 1'b0;
            track_num_reg  <= '0;
            track_done_reg <= 1'b0;
        end else begin
            state_reg      <= state_next;
            lock_reg       <= lock_next;
            rel_reg        <= rel_next;
            lock_vld_reg   <= lock_vld_next;
            track_pos_reg  <= track_pos_next;
            track_num_reg  <= track_num_next;
            track_done_reg <= track_done_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        lock_next       = lock_reg;
        rel_next        = rel_reg;
        lock_vld_next   = lock_vld_reg;
        track_pos_next  = 1'b0;
        track_num_next  = track_num_reg;
        track_done_next = track_done_reg;
        sec_load        = 1'b0;
        sec_upd         = 1'b0;
        if (soft_rst) begin
            state_next      = IDLE;
            lock_next       = '0;
            rel_next        = '0;
            lock_vld_next   = 1'b0;
            track_num_next  = '0;
            track_done_next = 1'b0;
        end else if (!fir_en) begin
            // Disabling drops the lock but keeps the count so a later run continues it.
            state_next      = IDLE;
            lock_next       = '0;
            lock_vld_next   = 1'b0;
            track_done_next = 1'b0;
        end else begin
            case (state_reg)
                IDLE: state_next = LOCK;
                LOCK: begin
                    if (enc_vld) begin
                        lock_next     = angle;
                        lock_vld_next = 1'b1;
                        rel_next      = '0;
                        sec_load      = 1'b1;
                        state_next    = WAIT_ARM;
                    end
                end
                WAIT_ARM: begin
                    if (enc_vld) begin
                        rel_next = rel_cur;
                        sec_upd  = 1'b1;
                        if (quad == 2'b10) state_next = ARMED;
                    end
                end
                ARMED: begin
                    if (enc_vld) begin
                        rel_next = rel_cur;
                        sec_upd  = 1'b1;
                        if (quad == 2'b00) begin
                            track_pos_next = 1'b1;
                            track_num_next = num_inc;
                            if ((cfg_track_max != '0) && (num_inc == cfg_track_max)) begin
                                state_next      = DONE;
                                track_done_next = 1'b1;
                            end else begin
                                state_next = WAIT_ARM;
                            end
                        end
                    end
                end
                DONE: begin
                    if (enc_vld) rel_next = rel_cur;
                end
                default: state_next = IDLE;
            endcase
        end
    end

    assign lock_vld   = lock_vld_reg;
    assign rel_angle  = rel_reg;
    assign track_pos  = track_pos_reg;
    assign track_num  = track_num_reg;
    assign track_done = track_done_reg;

`ifdef TRACK_SEG_SECTOR_EN
    logic [SEC_BITS-1:0] sector_idx_reg;
    logic                sector_pos_reg;
    logic [SEC_BITS-1:0] sec_new;
    logic [SEC_BITS-1:0] sec_inc;

    assign sec_new = rel_cur[ENC_W-1 -: SEC_BITS];
    assign sec_inc = sector_idx_reg + 1'b1;

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            sector_idx_reg <= '0;
            sector_pos_reg <= 1'b0;
        end else if (soft_rst) begin
            sector_idx_reg <= '0;
            sector_pos_reg <= 1'b0;
        end else begin
            sector_pos_reg <= 1'b0;
            if (sec_load) begin
                sector_idx_reg <= '0;
            end else if (sec_upd) begin
                // Only a single forward step pulses; skips and reversals just move the index.
                sector_pos_reg <= (sec_new == sec_inc);
                sector_idx_reg <= sec_new;
            end
        end
    end

    assign sector_pos = sector_pos_reg;
    assign sector_idx = sector_idx_reg;
`else
    logic unused_sec;
    assign unused_sec = sec_load ^ sec_upd;
    assign sector_pos = 1'b0;
    assign sector_idx = '0;
`endif

endmodule

// File: tb/tb_track_seg_gen.sv
// Bench for track_seg_gen: directed scenarios plus random sweeps against a flag-based model.
module tb_track_seg_gen;

    localparam int DIN_W = 64, ENC_LSB = 34, ENC_W = 18, NUM_W = 16, SEC_BITS = 3;
    localparam int unsigned MASK = (1 << ENC_W) - 1;
    localparam int unsigned QV = 1 << (ENC_W - 2);
    localparam int unsigned HV = 1 << (ENC_W - 1);
    localparam int unsigned TV = 3 * QV;
    localparam int unsigned MAXN = (1 << NUM_W) - 1;
`ifdef TRACK_SEG_SECTOR_EN
    localparam bit SEC_EN = 1'b1;
`else
    localparam bit SEC_EN = 1'b0;
`endif

    logic                sys_clk, sys_rst, soft_rst, fir_en, enc_vld;
    logic [DIN_W-1:0]    enc_din;
    logic [NUM_W-1:0]    cfg_track_max;
    logic                lock_vld, track_pos, track_done, sector_pos;
    logic [ENC_W-1:0]    rel_angle;
    logic [NUM_W-1:0]    track_num;
    logic [SEC_BITS-1:0] sector_idx;

    track_seg_gen #(
        .DIN_W(DIN_W), .ENC_LSB(ENC_LSB), .ENC_W(ENC_W), .NUM_W(NUM_W), .SEC_BITS(SEC_BITS)
    ) dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .soft_rst(soft_rst), .fir_en(fir_en),
        .enc_vld(enc_vld), .enc_din(enc_din), .cfg_track_max(cfg_track_max),
        .lock_vld(lock_vld), .rel_angle(rel_angle), .track_pos(track_pos),
        .track_num(track_num), .track_done(track_done), .sector_pos(sector_pos),
        .sector_idx(sector_idx)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    int total = 0;
    int bad = 0;

    // Model: enabled/locked/armed/done flags plus the expected outputs.
    bit          m_en, m_locked, m_armed, m_done;
    int unsigned m_lock;
    bit          e_lv, e_tp, e_td, e_sp;
    int unsigned e_rel, e_tn, e_si;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model(input bit sr, input bit fe, input bit vld, input int unsigned ang);
        int unsigned rel, ni;
        e_tp = 0;
        e_sp = 0;
        if (sr) begin
            m_en = 0; m_locked = 0; m_armed = 0; m_done = 0; m_lock = 0;
            e_lv = 0; e_td = 0; e_rel = 0; e_tn = 0; e_si = 0;
        end else if (!fe) begin
            m_en = 0; m_locked = 0; m_armed = 0; m_done = 0;
            e_lv = 0; e_td = 0;
        end else if (!m_en) begin
            m_en = 1;
        end else if (vld) begin
            if (!m_locked) begin
                m_locked = 1; m_lock = ang; e_lv = 1; e_rel = 0; e_si = 0;
            end else begin
                rel = (ang - m_lock) & MASK;
                e_rel = rel;
                if (!m_done) begin
                    ni = rel >> (ENC_W - SEC_BITS);
                    if (SEC_EN) begin
                        e_sp = (ni == ((e_si + 1) % (1 << SEC_BITS)));
                        e_si = ni;
                    end
                    if (!m_armed) begin
                        m_armed = (rel >= HV) && (rel < TV);
                    end else if (rel < QV) begin
                        e_tp = 1;
                        if (e_tn != MAXN) e_tn++;
                        m_armed = 0;
                        if (cfg_track_max != 0 && e_tn == cfg_track_max) begin
                            m_done = 1;
                            e_td = 1;
                        end
                    end
                end
            end
        end
    endtask

    task automatic step(input bit sr, input bit fe, input bit vld, input int unsigned ang);
        soft_rst = sr;
        fir_en   = fe;
        enc_vld  = vld;
        enc_din  = {$urandom, $urandom};
        enc_din[ENC_LSB +: ENC_W] = ang[ENC_W-1:0];
        @(posedge sys_clk);
        model(sr, fe, vld, ang & MASK);
        #1;
        check("lock_vld", lock_vld, e_lv);
        check("rel_angle", rel_angle, e_rel);
        check("track_pos", track_pos, e_tp);
        check("track_num", track_num, e_tn);
        check("track_done", track_done, e_td);
        check("sector_pos", sector_pos, e_sp);
        check("sector_idx", sector_idx, e_si);
    endtask

    // One revolution relative to a lock angle; the last sample completes the track.
    task automatic rev(input int unsigned base, output int pulses);
        int unsigned offs [5] = '{69000, 139000, 199000, 259000, 500};
        pulses = 0;
        foreach (offs[i]) begin
            step(0, 1, 1, (base + offs[i]) & MASK);
            pulses += int'(track_pos);
        end
    endtask

    initial begin
        int n, p;
        int unsigned cur;
        sys_rst = 1; soft_rst = 0; fir_en = 0; enc_vld = 0; enc_din = '0; cfg_track_max = '0;
        m_en = 0; m_locked = 0; m_armed = 0; m_done = 0; m_lock = 0;
        e_lv = 0; e_tp = 0; e_td = 0; e_sp = 0; e_rel = 0; e_tn = 0; e_si = 0;
        repeat (2) @(posedge sys_clk);
        #1;
        check("rst_lock_vld", lock_vld, 0);
        check("rst_rel_angle", rel_angle, 0);
        check("rst_track_num", track_num, 0);
        check("rst_track_pos", track_pos, 0);
        check("rst_track_done", track_done, 0);
        sys_rst = 0;

        // Lock then one full revolution
        step(0, 1, 0, 0);
        step(0, 1, 1, 1000);
        check("lock_flag", lock_vld, 1);
        check("lock_rel", rel_angle, 0);
        check("lock_num", track_num, 0);
        rev(1000, p);
        check("rev_pos_last", track_pos, 1);
        check("rev_num", track_num, 1);
        check("rev_pulses", p, 1);

        // Jitter around the lock point must not arm
        n = 0;
        for (int i = 0; i < 100; i++) begin
            step(0, 1, 1, (i % 2 == 0) ? 999 : 1001);
            n += int'(track_pos);
        end
        check("jitter_pulses", n, 0);
        rev(1000, p);
        check("jitter_then_rev", track_num, 2);

        // Track limit of 2
        step(1, 1, 1, 0);
        cfg_track_max = 2;
        step(0, 1, 0, 0);
        step(0, 1, 1, 5000);
        n = 0;
        for (int r = 0; r < 3; r++) begin
            rev(5000, p);
            n += p;
            if (r == 1) check("limit_done_2nd", track_done, 1);
        end
        check("limit_pulses", n, 2);
        check("limit_num", track_num, 2);
        check("limit_done", track_done, 1);

        // soft_rst while armed with five tracks counted
        cfg_track_max = 0;
        step(1, 1, 0, 0);
        step(0, 1, 0, 0);
        step(0, 1, 1, 30000);
        for (int r = 0; r < 5; r++) rev(30000, p);
        step(0, 1, 1, 30000 + 139000);
        step(1, 1, 1, 30000 + 500);
        check("srst_num", track_num, 0);
        check("srst_lock", lock_vld, 0);
        check("srst_rel", rel_angle, 0);

        // fir_en drop keeps the count; relock continues from it
        step(0, 1, 0, 0);
        step(0, 1, 1, 200);
        for (int r = 0; r < 5; r++) rev(200, p);
        step(0, 0, 0, 0);
        check("drop_lock", lock_vld, 0);
        check("drop_num", track_num, 5);
        step(0, 1, 0, 0);
        step(0, 1, 1, 77777);
        rev(77777, p);
        check("reenable_num", track_num, 6);

        // Sector sweep from lock 0 through a full turn and back to 0
        step(1, 1, 0, 0);
        step(0, 1, 0, 0);
        step(0, 1, 1, 0);
        n = 0;
        for (int a = 4096; a < 262144; a += 4096) begin
            step(0, 1, 1, a);
            n += int'(sector_pos);
        end
        step(0, 1, 1, 0);
        n += int'(sector_pos);
        check("sweep_sector_pulses", n, SEC_EN ? 8 : 0);
        check("sweep_track_pos", track_pos, 1);
        check("sweep_coincident", sector_pos, SEC_EN);

        // Randomised traffic
        cur = $urandom & MASK;
        for (int i = 0; i < 3000; i++) begin
            int r;
            bit sr, fe;
            r = $urandom_range(0, 199);
            sr = (r == 0);
            fe = !(r inside {[1:3]});
            if ($urandom_range(0, 99) == 0) cfg_track_max = NUM_W'($urandom_range(0, 4));
            case ($urandom_range(0, 9))
                0:       cur = (cur - $urandom_range(0, 3000)) & MASK;
                1:       cur = (cur + $urandom_range(0, 4)) & MASK;
                default: cur = (cur + $urandom_range(0, 40000)) & MASK;
            endcase
            step(sr, fe, $urandom_range(0, 3) != 0, cur);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
